// File: rtl/id_stage_hazard.sv
// id_stage_hazard: MIPS-style decode stage with a register file, write-back bypass,
// load-use stall detection and a registered decode-to-execute pipeline register.
module id_stage_hazard #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic [31:0]       ir,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              dx_valid,
  output logic              dx_jump,
  output logic              dx_branch,
  output logic              dx_memwrite,
  output logic              dx_memtoreg,
  output logic              dx_regwrite,
  output logic              dx_alusrc,
  output logic              dx_illegal,
  output logic [2:0]        dx_aluctr,
  output logic [AW-1:0]     dx_rd,
  output logic [AW-1:0]     dx_rs,
  output logic [AW-1:0]     dx_rt,
  output logic [31:0]       dx_pc,
  output logic [31:0]       dx_jaddr,
  output logic [DATA_W-1:0] dx_a,
  output logic [DATA_W-1:0] dx_b,
  output logic [DATA_W-1:0] dx_imm
);
  logic [DATA_W-1:0] rf_q [REG_NUM];
  logic [DATA_W-1:0] rf_d [REG_NUM];
  logic [5:0] op, fn;
  logic [AW-1:0] rs, rt, rd;
  logic jump, branch, memwrite, memtoreg, regwrite, alusrc, illegal, rd_r, zext, rt_use;
  logic [2:0] aluctr;
  logic [DATA_W-1:0] a, b, imm;
  logic hazard, issue;
  logic valid_d, jump_d, branch_d, memwrite_d, memtoreg_d, regwrite_d, alusrc_d, illegal_d;
  logic valid_q, jump_q, branch_q, memwrite_q, memtoreg_q, regwrite_q, alusrc_q, illegal_q;
  logic [2:0] aluctr_d, aluctr_q;
  logic [AW-1:0] rd_d, rd_q, rs_d, rs_q, rt_d, rt_q;
  logic [31:0] pc_d, pc_q, jaddr_d, jaddr_q;
  logic [DATA_W-1:0] a_d, a_q, b_d, b_q, imm_d, imm_q;

  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign rs = ir[21 +: AW];
  assign rt = ir[16 +: AW];

  always_comb begin
    rf_d = rf_q;
    if (wb_we && wb_rd != '0) rf_d[wb_rd] = wb_data;
  end

  always_comb begin
    jump     = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrc   = 1'b0;
    illegal  = 1'b0;
    rd_r     = 1'b0;
    zext     = 1'b0;
    aluctr   = 3'b010;
    case (op)
      6'b000000: begin
        regwrite = 1'b1;
        rd_r     = 1'b1;
        case (fn)
          6'b100000: aluctr = 3'b010;
          6'b100010: aluctr = 3'b110;
          6'b100100: aluctr = 3'b000;
          6'b100101: aluctr = 3'b001;
          6'b101010: aluctr = 3'b111;
          default: begin
            illegal  = 1'b1;
            regwrite = 1'b0;
          end
        endcase
      end
      6'b001000: {regwrite, alusrc} = 2'b11;
      6'b001010: {regwrite, alusrc, aluctr} = {2'b11, 3'b111};
      6'b001100: {regwrite, alusrc, zext, aluctr} = {3'b111, 3'b000};
      6'b001101: {regwrite, alusrc, zext, aluctr} = {3'b111, 3'b001};
      6'b100011: {regwrite, alusrc, memtoreg} = 3'b111;
      6'b101011: {alusrc, memwrite} = 2'b11;
      6'b000100: {branch, aluctr} = {1'b1, 3'b110};
      6'b000010: jump = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

  assign rd     = regwrite ? (rd_r ? ir[11 +: AW] : ir[16 +: AW]) : '0;
  assign imm    = zext ? {{(DATA_W-16){1'b0}}, ir[15:0]} : {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign rt_use = op == 6'b000000 || op == 6'b000100 || op == 6'b101011;
  // Write-through makes a same-cycle write-back visible to the instruction being decoded
  assign a = (BYPASS != 0 && wb_we && wb_rd != '0 && wb_rd == rs) ? wb_data : rf_q[rs];
  assign b = (BYPASS != 0 && wb_we && wb_rd != '0 && wb_rd == rt) ? wb_data : rf_q[rt];

  assign hazard   = if_valid && !flush && valid_q && memtoreg_q && rd_q != '0 &&
                    (rd_q == rs || (rt_use && rd_q == rt));
  assign id_stall = hazard;
  assign issue    = if_valid && !flush && !hazard;

  always_comb begin
    valid_d    = issue;
    jump_d     = issue && jump;
    branch_d   = issue && branch;
    memwrite_d = issue && memwrite;
    memtoreg_d = issue && memtoreg;
    regwrite_d = issue && regwrite;
    alusrc_d   = issue && alusrc;
    illegal_d  = issue && illegal;
    aluctr_d   = aluctr;
    rd_d       = issue ? rd : '0;
    rs_d       = rs;
    rt_d       = rt;
    pc_d       = pc;
    jaddr_d    = {pc[31:28], ir[25:0], 2'b00};
    a_d        = a;
    b_d        = b;
    imm_d      = imm;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q <= '{default: '0};
      {valid_q, jump_q, branch_q, memwrite_q, memtoreg_q, regwrite_q, alusrc_q, illegal_q} <= '0;
      aluctr_q <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      pc_q     <= '0;
      jaddr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
    end else begin
      rf_q <= rf_d;
      {valid_q, jump_q, branch_q, memwrite_q, memtoreg_q, regwrite_q, alusrc_q, illegal_q} <=
        {valid_d, jump_d, branch_d, memwrite_d, memtoreg_d, regwrite_d, alusrc_d, illegal_d};
      aluctr_q <= aluctr_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      pc_q     <= pc_d;
      jaddr_q  <= jaddr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
    end
  end

  assign dx_valid    = valid_q;
  assign dx_jump     = jump_q;
  assign dx_branch   = branch_q;
  assign dx_memwrite = memwrite_q;
  assign dx_memtoreg = memtoreg_q;
  assign dx_regwrite = regwrite_q;
  assign dx_alusrc   = alusrc_q;
  assign dx_illegal  = illegal_q;
  assign dx_aluctr   = aluctr_q;
  assign dx_rd       = rd_q;
  assign dx_rs       = rs_q;
  assign dx_rt       = rt_q;
  assign dx_pc       = pc_q;
  assign dx_jaddr    = jaddr_q;
  assign dx_a        = a_q;
  assign dx_b        = b_q;
  assign dx_imm      = imm_q;
endmodule

// File: tb/tb_id_stage_hazard.sv
// tb_id_stage_hazard: directed checks of decode, register file, bypass, load-use stall,
// flush and asynchronous reset, with a second instance built without bypass.
module tb_id_stage_hazard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] pc = '0, ir = '0;
  logic if_valid = 1'b0, flush = 1'b0, wb_we = 1'b0;
  logic [4:0] wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic id_stall, dx_valid, dx_jump, dx_branch, dx_memwrite, dx_memtoreg, dx_regwrite, dx_alusrc, dx_illegal;
  logic [2:0] dx_aluctr;
  logic [4:0] dx_rd, dx_rs, dx_rt;
  logic [31:0] dx_pc, dx_jaddr, dx_a, dx_b, dx_imm;
  logic nb_stall, nb_valid, nb_jump, nb_branch, nb_memwrite, nb_memtoreg, nb_regwrite, nb_alusrc, nb_illegal;
  logic [2:0] nb_aluctr;
  logic [4:0] nb_rd, nb_rs, nb_rt;
  logic [31:0] nb_pc, nb_jaddr, nb_a, nb_b, nb_imm;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_stage_hazard u_dut (
    .clk(clk), .rst(rst), .pc(pc), .ir(ir), .if_valid(if_valid), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .id_stall(id_stall),
    .dx_valid(dx_valid), .dx_jump(dx_jump), .dx_branch(dx_branch), .dx_memwrite(dx_memwrite),
    .dx_memtoreg(dx_memtoreg), .dx_regwrite(dx_regwrite), .dx_alusrc(dx_alusrc),
    .dx_illegal(dx_illegal), .dx_aluctr(dx_aluctr), .dx_rd(dx_rd), .dx_rs(dx_rs), .dx_rt(dx_rt),
    .dx_pc(dx_pc), .dx_jaddr(dx_jaddr), .dx_a(dx_a), .dx_b(dx_b), .dx_imm(dx_imm)
  );

  id_stage_hazard #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .pc(pc), .ir(ir), .if_valid(if_valid), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .id_stall(nb_stall),
    .dx_valid(nb_valid), .dx_jump(nb_jump), .dx_branch(nb_branch), .dx_memwrite(nb_memwrite),
    .dx_memtoreg(nb_memtoreg), .dx_regwrite(nb_regwrite), .dx_alusrc(nb_alusrc),
    .dx_illegal(nb_illegal), .dx_aluctr(nb_aluctr), .dx_rd(nb_rd), .dx_rs(nb_rs), .dx_rt(nb_rt),
    .dx_pc(nb_pc), .dx_jaddr(nb_jaddr), .dx_a(nb_a), .dx_b(nb_b), .dx_imm(nb_imm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (dx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", dx_valid); end
    n_checks++; if (dx_a !== 32'h0) begin n_fail++; $display("FAIL reset_a got %h exp 0", dx_a); end
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", id_stall); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_rtype();
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234; if_valid = 1'b0;
    step();
    wb_we = 1'b0; ir = 32'h00A01820; if_valid = 1'b1;
    step();
    n_checks++; if (dx_a !== 32'h1234) begin n_fail++; $display("FAIL add_a got %h exp 1234", dx_a); end
    n_checks++; if (dx_b !== 32'h0) begin n_fail++; $display("FAIL add_b got %h exp 0", dx_b); end
    n_checks++; if (dx_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd got %0d exp 3", dx_rd); end
    n_checks++; if (dx_aluctr !== 3'b010) begin n_fail++; $display("FAIL add_aluctr got %b exp 010", dx_aluctr); end
    n_checks++; if ({dx_valid, dx_regwrite, dx_alusrc} !== 3'b110) begin n_fail++; $display("FAIL add_ctl got %b exp 110", {dx_valid, dx_regwrite, dx_alusrc}); end
    ir = 32'h00A01822;
    step();
    n_checks++; if (dx_aluctr !== 3'b110) begin n_fail++; $display("FAIL sub_aluctr got %b exp 110", dx_aluctr); end
  endtask

  task automatic test_load_use();
    ir = 32'h8C440008; if_valid = 1'b1;
    step();
    n_checks++; if ({dx_memtoreg, dx_rd, dx_imm} !== {1'b1, 5'd4, 32'd8}) begin n_fail++; $display("FAIL lw_dec got %b/%0d/%h exp 1/4/8", dx_memtoreg, dx_rd, dx_imm); end
    ir = 32'h00813020;
    #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b exp 1", id_stall); end
    step();
    n_checks++; if ({dx_valid, dx_regwrite, dx_rd} !== 7'b0) begin n_fail++; $display("FAIL lu_bubble got %b exp 0", {dx_valid, dx_regwrite, dx_rd}); end
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lu_clear got %b exp 0", id_stall); end
    step();
    n_checks++; if ({dx_valid, dx_rd} !== {1'b1, 5'd6}) begin n_fail++; $display("FAIL lu_issue got %b/%0d exp 1/6", dx_valid, dx_rd); end
  endtask

  task automatic test_flush();
    ir = 32'h8C440008; if_valid = 1'b1;
    step();
    ir = 32'h00813020; flush = 1'b1;
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall got %b exp 0", id_stall); end
    step();
    n_checks++; if (dx_valid !== 1'b0) begin n_fail++; $display("FAIL fl_bubble got %b exp 0", dx_valid); end
    flush = 1'b0; if_valid = 1'b0;
    step();
    n_checks++; if (dx_valid !== 1'b0) begin n_fail++; $display("FAIL fl_noissue got %b exp 0", dx_valid); end
  endtask

  task automatic test_bypass();
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h1111; if_valid = 1'b0;
    step();
    wb_data = 32'hCAFE; ir = 32'h00E00820; if_valid = 1'b1;
    step();
    wb_we = 1'b0;
    n_checks++; if (dx_a !== 32'hCAFE) begin n_fail++; $display("FAIL byp_a got %h exp cafe", dx_a); end
    n_checks++; if (nb_a !== 32'h1111) begin n_fail++; $display("FAIL nobyp_a got %h exp 1111", nb_a); end
    step();
    n_checks++; if (nb_a !== 32'hCAFE) begin n_fail++; $display("FAIL nobyp_later got %h exp cafe", nb_a); end
  endtask

  task automatic test_imm();
    ir = 32'h34028000; if_valid = 1'b1;
    step();
    n_checks++; if ({dx_imm, dx_alusrc, dx_rd} !== {32'h00008000, 1'b1, 5'd2}) begin n_fail++; $display("FAIL ori got %h/%b/%0d exp 00008000/1/2", dx_imm, dx_alusrc, dx_rd); end
    n_checks++; if (dx_aluctr !== 3'b001) begin n_fail++; $display("FAIL ori_aluctr got %b exp 001", dx_aluctr); end
    ir = 32'h20028000;
    step();
    n_checks++; if (dx_imm !== 32'hFFFF8000) begin n_fail++; $display("FAIL addi_imm got %h exp ffff8000", dx_imm); end
    ir = 32'hFC000000;
    step();
    n_checks++; if ({dx_valid, dx_illegal, dx_regwrite, dx_aluctr} !== 6'b110010) begin n_fail++; $display("FAIL illegal got %b exp 110010", {dx_valid, dx_illegal, dx_regwrite, dx_aluctr}); end
    ir = 32'h00A0183F;
    step();
    n_checks++; if ({dx_illegal, dx_regwrite, dx_rd} !== 7'b1000000) begin n_fail++; $display("FAIL bad_funct got %b exp 1000000", {dx_illegal, dx_regwrite, dx_rd}); end
  endtask

  task automatic test_ctrl();
    pc = 32'h40000010; ir = 32'h08000100;
    step();
    n_checks++; if ({dx_jump, dx_jaddr} !== {1'b1, 32'h40000400}) begin n_fail++; $display("FAIL j got %b/%h exp 1/40000400", dx_jump, dx_jaddr); end
    n_checks++; if (dx_pc !== 32'h40000010) begin n_fail++; $display("FAIL j_pc got %h exp 40000010", dx_pc); end
    ir = 32'hACA3FFFC;
    step();
    n_checks++; if ({dx_memwrite, dx_regwrite, dx_rd, dx_imm} !== {2'b10, 5'd0, 32'hFFFFFFFC}) begin n_fail++; $display("FAIL sw got %b%b/%0d/%h exp 10/0/fffffffc", dx_memwrite, dx_regwrite, dx_rd, dx_imm); end
    ir = 32'h10A00004;
    step();
    n_checks++; if ({dx_branch, dx_alusrc, dx_aluctr} !== 5'b10110) begin n_fail++; $display("FAIL beq got %b exp 10110", {dx_branch, dx_alusrc, dx_aluctr}); end
  endtask

  task automatic test_zero_reg();
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF; ir = 32'h00000820; if_valid = 1'b1;
    step();
    wb_we = 1'b0;
    step();
    n_checks++; if (dx_a !== 32'h0) begin n_fail++; $display("FAIL r0_a got %h exp 0", dx_a); end
  endtask

  task automatic test_async_reset();
    ir = 32'h8C440008; if_valid = 1'b1;
    step();
    ir = 32'h00813020;
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if ({dx_valid, dx_memtoreg, dx_regwrite, dx_rd, dx_imm} !== 40'h0) begin n_fail++; $display("FAIL rst_async got %b/%h exp 0", {dx_valid, dx_memtoreg, dx_regwrite, dx_rd}, dx_imm); end
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", id_stall); end
    step();
    #2;
    rst = 1'b1;
    ir = 32'h00A01820;
    step();
    n_checks++; if ({dx_valid, dx_rd, dx_a} !== {1'b1, 5'd3, 32'h0}) begin n_fail++; $display("FAIL rst_after got %b/%0d/%h exp 1/3/0", dx_valid, dx_rd, dx_a); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_flush();
    test_bypass();
    test_imm();
    test_ctrl();
    test_zero_reg();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
